// File: rtl/trig_capture_40mhz_if.sv
// Control and trigger-readout signals between the trigger capture block and its readout.
// The master drives the control pulses and the slave returns the latched trigger and counters.
interface trig_capture_40mhz_if #(
   parameter int unsigned TS_WIDTH  = 32,
   parameter int unsigned CNT_WIDTH = 24
);
   logic                 ENABLE;
   logic                 TRIG_IN;
   logic                 TRIG_ACK;
   logic                 CLR_COUNTS;
   logic                 TRIG_OUT;
   logic [TS_WIDTH-1:0]  TRIG_TIME;
   logic [CNT_WIDTH-1:0] TRIG_COUNT;
   logic [CNT_WIDTH-1:0] MISSED_COUNT;
   logic                 BUSY;

   modport master (
      output ENABLE, TRIG_IN, TRIG_ACK, CLR_COUNTS,
      input  TRIG_OUT, TRIG_TIME, TRIG_COUNT, MISSED_COUNT, BUSY
   );

   modport slave (
      input  ENABLE, TRIG_IN, TRIG_ACK, CLR_COUNTS,
      output TRIG_OUT, TRIG_TIME, TRIG_COUNT, MISSED_COUNT, BUSY
   );
endinterface

// File: rtl/trig_capture_40mhz.sv
// 40 MHz compatibility trigger capture: latches one trigger with its timestamp until acknowledged,
// then holds off for a programmable dead time while counting accepted and missed triggers.
module trig_capture_40mhz #(
   parameter int unsigned DEAD_TIME = 2048,
   parameter int unsigned CNT_WIDTH = 24,
   parameter int unsigned TS_WIDTH  = 32
) (
   input  logic CLK120,
   input  logic RESETN,
   trig_capture_40mhz_if.slave bus
);
   localparam int unsigned DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PENDING, ST_DEAD} state_t;

   state_t               r_state, w_state_nxt;
   logic [TS_WIDTH-1:0]  r_ts;
   logic [DEAD_W-1:0]    r_dead, w_dead_nxt;
   logic                 r_trig_out, w_trig_out_nxt;
   logic [TS_WIDTH-1:0]  r_trig_time, w_trig_time_nxt;
   logic [CNT_WIDTH-1:0] r_trig_cnt, w_trig_cnt_nxt;
   logic [CNT_WIDTH-1:0] r_miss_cnt, w_miss_cnt_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 w_miss_inc;

   // State and registered outputs
   always_ff @(posedge CLK120 or negedge RESETN) begin
      if (!RESETN) begin
         r_state     <= ST_IDLE;
         r_ts        <= '0;
         r_dead      <= '0;
         r_trig_out  <= 1'b0;
         r_trig_time <= '0;
         r_trig_cnt  <= '0;
         r_miss_cnt  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ts        <= r_ts + TS_WIDTH'(1);
         r_dead      <= w_dead_nxt;
         r_trig_out  <= w_trig_out_nxt;
         r_trig_time <= w_trig_time_nxt;
         r_trig_cnt  <= w_trig_cnt_nxt;
         r_miss_cnt  <= w_miss_cnt_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Next-state, capture and counter logic
   always_comb begin
      w_state_nxt     = r_state;
      w_dead_nxt      = r_dead;
      w_trig_out_nxt  = r_trig_out;
      w_trig_time_nxt = r_trig_time;
      w_trig_cnt_nxt  = r_trig_cnt;
      w_miss_cnt_nxt  = r_miss_cnt;
      w_miss_inc      = 1'b0;

      if (!bus.ENABLE) begin
         // Disabling discards any pending trigger without counting it
         w_state_nxt    = ST_IDLE;
         w_trig_out_nxt = 1'b0;
         w_dead_nxt     = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt    = ST_ARMED;
               w_trig_out_nxt = 1'b0;
            end
            ST_ARMED: begin
               if (bus.TRIG_IN) begin
                  w_state_nxt     = ST_PENDING;
                  w_trig_out_nxt  = 1'b1;
                  w_trig_time_nxt = r_ts;
                  w_trig_cnt_nxt  = r_trig_cnt + CNT_WIDTH'(1);
               end
            end
            ST_PENDING: begin
               w_miss_inc = bus.TRIG_IN;
               if (bus.TRIG_ACK) begin
                  w_trig_out_nxt = 1'b0;
                  if (DEAD_TIME == 0) begin
                     w_state_nxt = ST_ARMED;
                  end else begin
                     w_state_nxt = ST_DEAD;
                     w_dead_nxt  = DEAD_W'(DEAD_TIME - 32'd1);
                  end
               end
            end
            ST_DEAD: begin
               w_miss_inc = bus.TRIG_IN;
               if (r_dead == '0) begin
                  w_state_nxt = ST_ARMED;
               end else begin
                  w_dead_nxt = r_dead - DEAD_W'(1);
               end
            end
            default: begin
               w_state_nxt    = ST_IDLE;
               w_trig_out_nxt = 1'b0;
            end
         endcase
      end

      if (w_miss_inc && (r_miss_cnt != '1)) begin
         w_miss_cnt_nxt = r_miss_cnt + CNT_WIDTH'(1);
      end

      // Clear overrides any increment in the same cycle
      if (bus.CLR_COUNTS) begin
         w_trig_cnt_nxt = '0;
         w_miss_cnt_nxt = '0;
      end

      w_busy_nxt = (w_state_nxt == ST_PENDING) || (w_state_nxt == ST_DEAD);
   end

   assign bus.TRIG_OUT     = r_trig_out;
   assign bus.TRIG_TIME    = r_trig_time;
   assign bus.TRIG_COUNT   = r_trig_cnt;
   assign bus.MISSED_COUNT = r_miss_cnt;
   assign bus.BUSY         = r_busy;
endmodule
